riscv_core_vector_sequencer: RTL and testbench
==============================================

RISCV_CORE_VECTOR_SEQUENCER -- requirements
Module: riscv_core_vector_sequencer

Interface
REQ-001 Parameter EX_LAT, default 2: cycles from read-beat issue to writeback of that beat, range 1..8.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_val  input  1  vector op request valid.
REQ-005 req_rdy  output  1  sequencer accepts an op; high only in IDLE.
REQ-006 req_vd, req_vs1, req_vs2  input  5 each  destination and source vector register numbers.
REQ-007 req_vl  input  7  vector length in elements, 0..64; values above 64 clamp to 64.
REQ-008 stall  input  1  downstream hold; freezes issue and writeback.
REQ-009 v_raddr0, v_raddr1  output  5 each  regfile read register numbers (vs1, vs2).
REQ-010 v_ridx0, v_ridx1  output  6 each  regfile read start element of current beat.
REQ-011 beat_val  output  1  read beat presented to execute pipe this cycle.
REQ-012 v_wen_p  output  1  regfile write enable.
REQ-013 v_waddr_p  output  5  write register (vd); v_widx_p  output  6  write start element.
REQ-014 v_lanes  output  2  active lanes minus one for the writing beat.
REQ-015 done  output  1  one-cycle pulse when an op fully retires.

Function
REQ-016 FSM states: IDLE, ISSUE, DRAIN.
REQ-017 IDLE: op accepted on req_val && req_rdy; vd/vs1/vs2/vl latched; remaining count = clamped vl; next state ISSUE, or done pulse next cycle and stay IDLE if vl == 0.
REQ-018 ISSUE, stall low: one beat per cycle, beat_val=1, v_ridx0=v_ridx1=4*k for beat k, beat lanes = min(remaining,4)-1, remaining -= 4.
REQ-019 ISSUE: beat with remaining <= 4 is last; next state DRAIN.
REQ-020 Beat index never exceeds 60; element idx+3 <= 63, no wrap-around generated.
REQ-021 Each issued beat enters an EX_LAT-deep shift register carrying {valid, idx, lanes}; v_wen_p, v_widx_p, v_lanes driven from its output stage.
REQ-022 stall high: beat_val=0, v_wen_p=0, FSM, counters and shift register hold; read address/index outputs hold.
REQ-023 DRAIN: when shift register empty and stall low, done=1 for one cycle, next state IDLE.
REQ-024 Write of final beat of op N occurs at least one cycle before done; next op accepted no earlier than cycle after done.
REQ-025 Beats of an op write exactly ceil(vl/4) times; a 64-element op takes 16 issue cycles plus EX_LAT drain plus 1 done cycle.
REQ-026 v_waddr_p = latched vd for all beats of the op; no other value driven while v_wen_p high.

Reset
REQ-027 reset_n low: state IDLE, shift register cleared, all outputs 0 except req_rdy=1.
REQ-028 Reset mid-op: op abandoned, no further writes, no done pulse.

Configuration
REQ-029 Macro RISCV_VSEQ_PERF_EN defined: adds outputs perf_beats (32) counting issued beats and perf_stall_cycles (32) counting stall-high cycles in ISSUE/DRAIN, both reset to 0, wrapping at 2^32.
REQ-030 Macro undefined: these ports and counters absent; all other behaviour identical.

Structure
REQ-031 Shared package riscv_vec_pkg holds FSM state enum, VLMAX=64, LANES=4, element-index width 6, register-number width 5.
REQ-032 Sub-module riscv_vec_beat_pipe implements the EX_LAT-stage {valid, idx, lanes} shift register with hold on stall.

Verification
REQ-033 vl=64, vd=3, vs1=1, vs2=2, EX_LAT=2, no stall -> 16 beats idx 0,4,..,60, lanes=3, writes to reg 3 on cycles 3..18 after accept, done once.
REQ-034 vl=6 -> beats idx 0 (lanes 3) and 4 (lanes 1), exactly two writes, done.
REQ-035 vl=0 -> no beats, no writes, done pulse cycle after accept; vl=100 -> behaves as 64.
REQ-036 vl=16, stall high 3 cycles during beat 2 -> ridx held at 8, v_wen_p 0 while stalled, all 4 writes complete, done delayed exactly 3 cycles.
REQ-037 reset_n low mid-ISSUE of vl=64 -> no v_wen_p after reset, req_rdy=1, new op vl=4 then completes normally.
REQ-038 RISCV_VSEQ_PERF_EN defined, REQ-036 stimulus -> perf_beats=4, perf_stall_cycles=3.

Source files
------------

// File: rtl/riscv_vec_pkg.sv
// Shared types and constants for the vector sequencer: FSM states, vector geometry, field widths.
// The optional perf counters are enabled with RISCV_VSEQ_PERF_EN (see the sequencer top).
package riscv_vec_pkg;

   localparam int VLMAX  = 64;
   localparam int LANES  = 4;
   localparam int IDX_W  = 6;
   localparam int REG_W  = 5;
   localparam int VL_W   = 7;
   localparam int LANE_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } vseq_state_e;

   function automatic logic [VL_W-1:0] clamp_vl(input logic [VL_W-1:0] vl);
      if (vl > 7'd64) begin
         return 7'd64;
      end else begin
         return vl;
      end
   endfunction

   // Active lanes minus one for a beat that starts with 'rem' elements left (rem >= 1).
   function automatic logic [LANE_W-1:0] beat_lanes(input logic [VL_W-1:0] rem);
      if (rem >= 7'd4) begin
         return 2'd3;
      end else begin
         return 2'(rem[1:0] - 2'd1);
      end
   endfunction

endpackage

// File: rtl/riscv_vec_beat_pipe.sv
// LAT-deep {valid, idx, lanes} delay line modelling the execute pipe; the whole line
// freezes while hold_i is high.
module riscv_vec_beat_pipe
   import riscv_vec_pkg::*;
#(
   parameter int LAT = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              hold_i,
   input  logic              in_valid_i,
   input  logic [IDX_W-1:0]  in_idx_i,
   input  logic [LANE_W-1:0] in_lanes_i,
   output logic              out_valid_o,
   output logic [IDX_W-1:0]  out_idx_o,
   output logic [LANE_W-1:0] out_lanes_o,
   output logic              empty_o
);

   logic [LAT-1:0]    vld_q;
   logic [IDX_W-1:0]  idx_q   [LAT];
   logic [LANE_W-1:0] lanes_q [LAT];

   // Shift one stage per unheld cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= '0;
         for (int i = 0; i < LAT; i++) begin
            idx_q[i]   <= '0;
            lanes_q[i] <= '0;
         end
      end else if (!hold_i) begin
         vld_q[0]   <= in_valid_i;
         idx_q[0]   <= in_idx_i;
         lanes_q[0] <= in_lanes_i;
         for (int i = 1; i < LAT; i++) begin
            vld_q[i]   <= vld_q[i-1];
            idx_q[i]   <= idx_q[i-1];
            lanes_q[i] <= lanes_q[i-1];
         end
      end
   end

   assign out_valid_o = vld_q[LAT-1];
   assign out_idx_o   = idx_q[LAT-1];
   assign out_lanes_o = lanes_q[LAT-1];
   assign empty_o     = ~|vld_q;

endmodule

// File: rtl/riscv_core_vector_sequencer.sv
// Vector op sequencer: splits an op into 4-element read beats, tracks them through the
// execute delay line and retires with a done pulse. Define RISCV_VSEQ_PERF_EN for perf counters.
module riscv_core_vector_sequencer
   import riscv_vec_pkg::*;
#(
   parameter int EX_LAT = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_val,
   output logic              req_rdy,
   input  logic [REG_W-1:0]  req_vd,
   input  logic [REG_W-1:0]  req_vs1,
   input  logic [REG_W-1:0]  req_vs2,
   input  logic [VL_W-1:0]   req_vl,
   input  logic              stall,
   output logic [REG_W-1:0]  v_raddr0,
   output logic [REG_W-1:0]  v_raddr1,
   output logic [IDX_W-1:0]  v_ridx0,
   output logic [IDX_W-1:0]  v_ridx1,
   output logic              beat_val,
   output logic              v_wen_p,
   output logic [REG_W-1:0]  v_waddr_p,
   output logic [IDX_W-1:0]  v_widx_p,
   output logic [LANE_W-1:0] v_lanes,
   output logic              done
`ifdef RISCV_VSEQ_PERF_EN
   ,output logic [31:0]      perf_beats
   ,output logic [31:0]      perf_stall_cycles
`endif
);

   vseq_state_e       state_q, state_d;
   logic [REG_W-1:0]  vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
   logic [VL_W-1:0]   rem_q, rem_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              zdone_q, zdone_d;
   logic              drain_done;
   logic              pipe_in_valid;
   logic [IDX_W-1:0]  pipe_in_idx;
   logic [LANE_W-1:0] pipe_in_lanes;
   logic              pipe_out_valid;
   logic              pipe_empty;
   logic [VL_W-1:0]   vl_clamped;

   assign vl_clamped = clamp_vl(req_vl);

   // State and op-context registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         vd_q    <= '0;
         vs1_q   <= '0;
         vs2_q   <= '0;
         rem_q   <= '0;
         idx_q   <= '0;
         zdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         vd_q    <= vd_d;
         vs1_q   <= vs1_d;
         vs2_q   <= vs2_d;
         rem_q   <= rem_d;
         idx_q   <= idx_d;
         zdone_q <= zdone_d;
      end
   end

   // Next-state, beat issue and retire decode.
   always_comb begin
      state_d       = state_q;
      vd_d          = vd_q;
      vs1_d         = vs1_q;
      vs2_d         = vs2_q;
      rem_d         = rem_q;
      idx_d         = idx_q;
      zdone_d       = 1'b0;
      beat_val      = 1'b0;
      drain_done    = 1'b0;
      pipe_in_valid = 1'b0;
      pipe_in_idx   = '0;
      pipe_in_lanes = '0;
      case (state_q)
         ST_IDLE: begin
            if (req_val && req_rdy) begin
               vd_d  = req_vd;
               vs1_d = req_vs1;
               vs2_d = req_vs2;
               rem_d = vl_clamped;
               idx_d = '0;
               if (vl_clamped == 7'd0) begin
                  zdone_d = 1'b1;
               end else begin
                  state_d = ST_ISSUE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (!stall) begin
               beat_val      = 1'b1;
               pipe_in_valid = 1'b1;
               pipe_in_idx   = idx_q;
               pipe_in_lanes = beat_lanes(rem_q);
               // The last beat leaves idx parked so the read index never runs past 60.
               if (rem_q <= 7'd4) begin
                  rem_d   = '0;
                  state_d = ST_DRAIN;
               end else begin
                  rem_d = rem_q - 7'd4;
                  idx_d = idx_q + 6'd4;
               end
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_DRAIN: begin
            if (!stall && pipe_empty) begin
               drain_done = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   riscv_vec_beat_pipe #(
      .LAT (EX_LAT)
   ) u_beat_pipe (
      .clk         (clk),
      .reset_n     (reset_n),
      .hold_i      (stall),
      .in_valid_i  (pipe_in_valid),
      .in_idx_i    (pipe_in_idx),
      .in_lanes_i  (pipe_in_lanes),
      .out_valid_o (pipe_out_valid),
      .out_idx_o   (v_widx_p),
      .out_lanes_o (v_lanes),
      .empty_o     (pipe_empty)
   );

   // A zero-length op retires the cycle after accept; hold off the next accept until then.
   assign req_rdy   = (state_q == ST_IDLE) && !zdone_q;
   assign done      = drain_done | zdone_q;
   assign v_raddr0  = vs1_q;
   assign v_raddr1  = vs2_q;
   assign v_ridx0   = idx_q;
   assign v_ridx1   = idx_q;
   assign v_wen_p   = pipe_out_valid && !stall;
   assign v_waddr_p = vd_q;

`ifdef RISCV_VSEQ_PERF_EN
   logic [31:0] perf_beats_q, perf_stall_q;

   // Free-running wrap-around perf counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_beats_q <= '0;
         perf_stall_q <= '0;
      end else begin
         if (beat_val) begin
            perf_beats_q <= perf_beats_q + 32'd1;
         end
         if (stall && (state_q == ST_ISSUE || state_q == ST_DRAIN)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_beats        = perf_beats_q;
   assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_riscv_core_vector_sequencer.sv
// Directed scoreboard bench for riscv_core_vector_sequencer (EX_LAT = 2).
module tb_riscv_core_vector_sequencer;

   localparam int EX_LAT = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       req_val = 1'b0;
   logic       req_rdy;
   logic [4:0] req_vd = 5'd0, req_vs1 = 5'd0, req_vs2 = 5'd0;
   logic [6:0] req_vl = 7'd0;
   logic       stall = 1'b0;
   logic [4:0] v_raddr0, v_raddr1, v_waddr_p;
   logic [5:0] v_ridx0, v_ridx1, v_widx_p;
   logic       beat_val, v_wen_p, done;
   logic [1:0] v_lanes;
`ifdef RISCV_VSEQ_PERF_EN
   logic [31:0] perf_beats, perf_stall_cycles;
`endif

   riscv_core_vector_sequencer #(.EX_LAT(EX_LAT)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_val   (req_val),
      .req_rdy   (req_rdy),
      .req_vd    (req_vd),
      .req_vs1   (req_vs1),
      .req_vs2   (req_vs2),
      .req_vl    (req_vl),
      .stall     (stall),
      .v_raddr0  (v_raddr0),
      .v_raddr1  (v_raddr1),
      .v_ridx0   (v_ridx0),
      .v_ridx1   (v_ridx1),
      .beat_val  (beat_val),
      .v_wen_p   (v_wen_p),
      .v_waddr_p (v_waddr_p),
      .v_widx_p  (v_widx_p),
      .v_lanes   (v_lanes),
      .done      (done)
`ifdef RISCV_VSEQ_PERF_EN
      ,.perf_beats        (perf_beats)
      ,.perf_stall_cycles (perf_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] vs1;
      logic [4:0] vs2;
      logic [5:0] idx;
   } beat_t;

   typedef struct {
      logic [4:0] vd;
      logic [5:0] idx;
      logic [1:0] lanes;
      int         cyc;
   } wr_t;

   beat_t bq[$];
   wr_t   wq[$];
   beat_t b_m;
   wr_t   w_m;
   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   int    acc = 0;
   int    done_cnt = 0;
   int    off;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: pops read-beat and write expectations as the DUT produces them.
   always @(negedge clk) begin
      if (reset_n) begin
         if (beat_val === 1'b1) begin
            check("beat_expected", 64'(bq.size() != 0), 64'd1);
            if (bq.size() != 0) begin
               b_m = bq.pop_front();
               check("beat_rd", {v_raddr0, v_raddr1, v_ridx0, v_ridx1},
                     {b_m.vs1, b_m.vs2, b_m.idx, b_m.idx});
            end
         end
         if (v_wen_p === 1'b1) begin
            check("wr_expected", 64'(wq.size() != 0), 64'd1);
            if (wq.size() != 0) begin
               w_m = wq.pop_front();
               check("wr_fields", {v_waddr_p, v_widx_p, v_lanes}, {w_m.vd, w_m.idx, w_m.lanes});
               if (w_m.cyc >= 0) check("wr_cycle", 64'(cyc - acc), 64'(w_m.cyc));
            end
         end
         if (done === 1'b1) done_cnt++;
      end
   end

   task automatic start_op(input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                           input logic [6:0] vl, input bit timed);
      int n;
      int vlc;
      int rem;
      beat_t b;
      wr_t   w;
      n = 0;
      @(posedge clk); #1;
      while (req_rdy !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("req_rdy_before_op", 64'(req_rdy), 64'd1);
      req_val = 1'b1;
      req_vd  = vd;
      req_vs1 = vs1;
      req_vs2 = vs2;
      req_vl  = vl;
      acc     = cyc;
      vlc = (vl > 7'd64) ? 64 : int'(vl);
      rem = vlc;
      for (int k = 0; k * 4 < vlc; k++) begin
         b.vs1 = vs1; b.vs2 = vs2; b.idx = 6'(4 * k);
         bq.push_back(b);
         w.vd = vd; w.idx = 6'(4 * k);
         w.lanes = (rem >= 4) ? 2'd3 : 2'(rem - 1);
         w.cyc = timed ? (1 + k + EX_LAT) : -1;
         wq.push_back(w);
         rem -= 4;
      end
      @(posedge clk); #1;
      req_val = 1'b0;
   endtask

   task automatic wait_done(output int o);
      o = -1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            o = cyc - acc;
            break;
         end
      end
   endtask

   task automatic finish_op(input string tag, input int exp_off);
      int o;
      wait_done(o);
      check({tag, "_done_cycle"}, 64'(o), 64'(exp_off));
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
      check({tag, "_rdy_after"}, 64'(req_rdy), 64'd1);
      check({tag, "_beats_all"}, 64'(bq.size()), 64'd0);
      check({tag, "_writes_all"}, 64'(wq.size()), 64'd0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_rdy", 64'(req_rdy), 64'd1);
      check("rst_outs", {beat_val, v_wen_p, done, v_lanes}, 64'd0);
      check("rst_addrs", {v_raddr0, v_raddr1, v_ridx0, v_ridx1, v_waddr_p, v_widx_p}, 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // vl=16 with a 3-cycle stall over beat 2
      start_op(5'd9, 5'd4, 5'd5, 7'd16, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_ridx", {v_ridx0, v_ridx1}, {6'd8, 6'd8});
         check("stall_quiet", {beat_val, v_wen_p}, 64'd0);
         @(posedge clk); #1;
      end
      stall = 1'b0;
      finish_op("stall16", 4 + EX_LAT + 1 + 3);
`ifdef RISCV_VSEQ_PERF_EN
      check("perf_beats", 64'(perf_beats), 64'd4);
      check("perf_stall", 64'(perf_stall_cycles), 64'd3);
`endif

      // Full-length and odd-length ops
      start_op(5'd3, 5'd1, 5'd2, 7'd64, 1'b1);
      finish_op("vl64", 16 + EX_LAT + 1);
      start_op(5'd12, 5'd30, 5'd31, 7'd6, 1'b1);
      finish_op("vl6", 2 + EX_LAT + 1);
      start_op(5'd1, 5'd2, 5'd3, 7'd0, 1'b1);
      finish_op("vl0", 1);
      start_op(5'd17, 5'd18, 5'd19, 7'd100, 1'b1);
      finish_op("vl100", 16 + EX_LAT + 1);

      // Reset in the middle of a 64-element op
      start_op(5'd7, 5'd8, 5'd10, 7'd64, 1'b1);
      repeat (4) begin
         @(posedge clk); #1;
      end
      reset_n = 1'b0;
      bq.delete();
      wq.delete();
      @(negedge clk);
      check("midrst_rdy", 64'(req_rdy), 64'd1);
      check("midrst_outs", {beat_val, v_wen_p, done}, 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("postrst_quiet", {v_wen_p, done, req_rdy}, 64'd1);
      end
      start_op(5'd21, 5'd22, 5'd23, 7'd4, 1'b1);
      finish_op("vl4", 1 + EX_LAT + 1);

      repeat (3) @(negedge clk);
      check("done_pulses", 64'(done_cnt), 64'd6);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
